// File: rtl/preg_file_mp.sv
// Multi-ported physical register file with per-register ready bits, write bypass,
// write-collision flagging and an optional registered read stage.
module preg_file_mp #(
  parameter int XLEN     = 64,
  parameter int PRF_NUM  = 64,
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int NALLOC   = 2,
  parameter int RD_REG   = 0,
  parameter int ZERO_IDX = PRF_NUM - 1,
  localparam int IDX_W   = (PRF_NUM > 1) ? $clog2(PRF_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*IDX_W-1:0]    rd_idx_i,
  output logic [NRD*XLEN-1:0]     rd_data_o,
  output logic [NRD-1:0]          rd_rdy_o,
  input  logic [NWR-1:0]          wr_en_i,
  input  logic [NWR*IDX_W-1:0]    wr_idx_i,
  input  logic [NWR*XLEN-1:0]     wr_data_i,
  input  logic [NALLOC-1:0]       alloc_en_i,
  input  logic [NALLOC*IDX_W-1:0] alloc_idx_i,
  output logic                    wr_conflict_o
);

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (int'(idx) < PRF_NUM);
  endfunction

  function automatic logic idx_writable(input logic [IDX_W-1:0] idx);
    return idx_in_range(idx) && (int'(idx) != ZERO_IDX);
  endfunction

  logic [IDX_W-1:0] rd_idx    [NRD];
  logic [IDX_W-1:0] wr_idx    [NWR];
  logic [XLEN-1:0]  wr_data   [NWR];
  logic [IDX_W-1:0] alloc_idx [NALLOC];

  for (genvar k = 0; k < NRD; k++) begin : g_rd_unpack
    assign rd_idx[k] = rd_idx_i[k*IDX_W +: IDX_W];
  end
  for (genvar w = 0; w < NWR; w++) begin : g_wr_unpack
    assign wr_idx[w]  = wr_idx_i[w*IDX_W +: IDX_W];
    assign wr_data[w] = wr_data_i[w*XLEN +: XLEN];
  end
  for (genvar a = 0; a < NALLOC; a++) begin : g_alloc_unpack
    assign alloc_idx[a] = alloc_idx_i[a*IDX_W +: IDX_W];
  end

  // Zero-register and out-of-range targets are dropped here, so they never
  // reach the array, the bypass or the conflict detector.
  logic [NWR-1:0]    wr_ok;
  logic [NALLOC-1:0] alloc_ok;

  always_comb begin
    wr_ok    = '0;
    alloc_ok = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_ok[w] = wr_en_i[w] && idx_writable(wr_idx[w]);
    end
    for (int a = 0; a < NALLOC; a++) begin
      alloc_ok[a] = alloc_en_i[a] && idx_writable(alloc_idx[a]);
    end
  end

  always_comb begin
    wr_conflict_o = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_ok[i] && wr_ok[j] && (wr_idx[i] == wr_idx[j])) begin
          wr_conflict_o = 1'b1;
        end
      end
    end
  end

  logic [XLEN-1:0]    data_q [PRF_NUM];
  logic [PRF_NUM-1:0] rdy_q;

  // Later ports overwrite earlier ones; allocates are applied last so they win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < PRF_NUM; r++) begin
        data_q[r] <= '0;
      end
      rdy_q <= '1;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w]) begin
          data_q[wr_idx[w]] <= wr_data[w];
          rdy_q[wr_idx[w]]  <= 1'b1;
        end
      end
      for (int a = 0; a < NALLOC; a++) begin
        if (alloc_ok[a]) begin
          rdy_q[alloc_idx[a]] <= 1'b0;
        end
      end
    end
  end

  // Stage p0: combinational read with same-cycle write bypass
  logic [NRD*XLEN-1:0] rd_data_p0;
  logic [NRD-1:0]      rd_rdy_p0;

  always_comb begin
    rd_data_p0 = '0;
    rd_rdy_p0  = '0;
    for (int k = 0; k < NRD; k++) begin
      if (int'(rd_idx[k]) == ZERO_IDX) begin
        rd_rdy_p0[k] = 1'b1;
      end else if (idx_in_range(rd_idx[k])) begin
        rd_data_p0[k*XLEN +: XLEN] = data_q[rd_idx[k]];
        rd_rdy_p0[k]               = rdy_q[rd_idx[k]];
        for (int w = 0; w < NWR; w++) begin
          if (wr_ok[w] && (wr_idx[w] == rd_idx[k])) begin
            rd_data_p0[k*XLEN +: XLEN] = wr_data[w];
            rd_rdy_p0[k]               = 1'b1;
          end
        end
      end
    end
  end

  // Stage p1: optional output register
  if (RD_REG != 0) begin : g_rd_reg
    logic [NRD*XLEN-1:0] rd_data_p1;
    logic [NRD-1:0]      rd_rdy_p1;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_p1 <= '0;
        rd_rdy_p1  <= '1;
      end else begin
        rd_data_p1 <= rd_data_p0;
        rd_rdy_p1  <= rd_rdy_p0;
      end
    end

    assign rd_data_o = rd_data_p1;
    assign rd_rdy_o  = rd_rdy_p1;
  end else begin : g_rd_comb
    assign rd_data_o = rd_data_p0;
    assign rd_rdy_o  = rd_rdy_p0;
  end

endmodule

// File: tb/tb_preg_file_mp.sv
// Directed bench for preg_file_mp: one combinational-read and one registered-read
// instance share stimulus; expectations queue up and a monitor checks them.
module tb_preg_file_mp;
  localparam int XLEN  = 64;
  localparam int PRF   = 48;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int NAL   = 2;
  localparam int IDX_W = 6;
  localparam int ZERO  = PRF - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD*IDX_W-1:0]  rd_idx;
  logic [NWR-1:0]        wr_en;
  logic [NWR*IDX_W-1:0]  wr_idx;
  logic [NWR*XLEN-1:0]   wr_data;
  logic [NAL-1:0]        alloc_en;
  logic [NAL*IDX_W-1:0]  alloc_idx;
  logic [NRD*XLEN-1:0]   rd_data0, rd_data1;
  logic [NRD-1:0]        rd_rdy0, rd_rdy1;
  logic                  conf0, conf1;

  preg_file_mp #(.XLEN(XLEN), .PRF_NUM(PRF), .NRD(NRD), .NWR(NWR), .NALLOC(NAL),
                 .RD_REG(0), .ZERO_IDX(ZERO)) dut0 (
    .clk(clk), .rst(rst), .rd_idx_i(rd_idx), .rd_data_o(rd_data0), .rd_rdy_o(rd_rdy0),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_idx_i(alloc_idx), .wr_conflict_o(conf0));

  preg_file_mp #(.XLEN(XLEN), .PRF_NUM(PRF), .NRD(NRD), .NWR(NWR), .NALLOC(NAL),
                 .RD_REG(1), .ZERO_IDX(ZERO)) dut1 (
    .clk(clk), .rst(rst), .rd_idx_i(rd_idx), .rd_data_o(rd_data1), .rd_rdy_o(rd_rdy1),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_idx_i(alloc_idx), .wr_conflict_o(conf1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    int          kind;   // 0 = read port, 1 = conflict flag
    int          port;
    logic [63:0] data;
    logic        rdy;
    string       name;
  } exp_t;

  exp_t q0[$];  // checked in the issue cycle (combinational instance)
  exp_t q1[$];  // checked one cycle later (registered instance)
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_rd(input exp_t e, input logic [63:0] d, input logic r, input string tag);
    n_cmp++;
    if (d !== e.data || r !== e.rdy) begin
      n_bad++;
      $display("FAIL %s/%s port%0d cyc%0d: got data=%h rdy=%b, want data=%h rdy=%b",
               e.name, tag, e.port, cyc, d, r, e.data, e.rdy);
    end
  endtask

  task automatic check_bit(input exp_t e, input logic got, input string tag);
    n_cmp++;
    if (got !== e.rdy) begin
      n_bad++;
      $display("FAIL %s/%s cyc%0d: got conflict=%b, want %b", e.name, tag, cyc, got, e.rdy);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q0.size() > 0 && q0[0].stamp <= cyc) begin
      e = q0.pop_front();
      if (e.stamp != cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s stale: got stamp=%0d, want %0d", e.name, e.stamp, cyc);
      end else if (e.kind == 1) begin
        check_bit(e, conf0, "comb");
        check_bit(e, conf1, "reg");
      end else begin
        check_rd(e, rd_data0[e.port*XLEN +: XLEN], rd_rdy0[e.port], "comb");
      end
    end
    while (q1.size() > 0 && q1[0].stamp + 1 <= cyc) begin
      e = q1.pop_front();
      if (e.stamp + 1 != cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s stale-reg: got stamp=%0d, want %0d", e.name, e.stamp, cyc - 1);
      end else begin
        check_rd(e, rd_data1[e.port*XLEN +: XLEN], rd_rdy1[e.port], "reg");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    rd_idx = '0; wr_en = '0; wr_idx = '0; wr_data = '0; alloc_en = '0; alloc_idx = '0;
  endtask

  task automatic set_wr(input int p, input int idx, input logic [63:0] d);
    wr_en[p] = 1'b1;
    wr_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_alloc(input int p, input int idx);
    alloc_en[p] = 1'b1;
    alloc_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  // Reads idx on port p this cycle; both instances must deliver (d, r) for it.
  task automatic exp_rd(input int p, input int idx, input logic [63:0] d, input logic r,
                        input string nm);
    exp_t e;
    rd_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
    e.stamp = cyc; e.kind = 0; e.port = p; e.data = d; e.rdy = r; e.name = nm;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic exp_conf(input logic v, input string nm);
    exp_t e;
    e.stamp = cyc; e.kind = 1; e.port = 0; e.data = '0; e.rdy = v; e.name = nm;
    q0.push_back(e);
  endtask

  task automatic exp_rst_reg(input string nm);
    exp_t e;
    for (int k = 0; k < NRD; k++) begin
      e.stamp = cyc; e.kind = 0; e.port = k; e.data = '0; e.rdy = 1'b1; e.name = nm;
      q1.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear();
    step();
    exp_rst_reg("rst_out");
    step();
    rst = 1'b0;

    // Every index reads 0 / ready after reset.
    for (int c = 0; c < PRF / NRD; c++) begin
      clear();
      for (int k = 0; k < NRD; k++) exp_rd(k, c*NRD + k, 64'h0, 1'b1, "rst_all");
      step();
    end

    // Bypass then array read.
    clear(); set_wr(0, 5, 64'hDEAD_BEEF);
    exp_rd(0, 5, 64'hDEAD_BEEF, 1'b1, "byp5"); exp_conf(1'b0, "noconf5");
    step();
    clear(); exp_rd(0, 5, 64'hDEAD_BEEF, 1'b1, "arr5");
    step();

    // Allocate clears ready from the next cycle; a later write restores it.
    clear(); set_alloc(0, 9); exp_rd(1, 9, 64'h0, 1'b1, "alloc9_t");
    step();
    clear(); exp_rd(1, 9, 64'h0, 1'b0, "alloc9_t1");
    step();
    clear(); exp_rd(1, 9, 64'h0, 1'b0, "alloc9_t2");
    step();
    clear(); set_wr(1, 9, 64'h1234); exp_rd(1, 9, 64'h1234, 1'b1, "wr9_byp");
    step();
    clear(); exp_rd(1, 9, 64'h1234, 1'b1, "wr9_arr");
    step();

    // Collision: highest port wins and the flag rises.
    clear(); set_wr(0, 7, 64'hAAAA); set_wr(1, 7, 64'hBBBB);
    exp_conf(1'b1, "conf7"); exp_rd(2, 7, 64'hBBBB, 1'b1, "byp7");
    step();
    clear(); exp_conf(1'b0, "conf_idle"); exp_rd(2, 7, 64'hBBBB, 1'b1, "arr7");
    step();
    clear(); set_wr(0, ZERO, 64'hAAAA); set_wr(1, ZERO, 64'hBBBB);
    exp_conf(1'b0, "conf_zero"); exp_rd(3, ZERO, 64'h0, 1'b1, "zero_byp");
    step();
    clear(); set_alloc(1, ZERO); exp_rd(3, ZERO, 64'h0, 1'b1, "zero_arr");
    step();
    clear(); exp_rd(3, ZERO, 64'h0, 1'b1, "zero_alloc");
    step();

    // Distinct targets on both ports: no conflict, both bypassed.
    clear(); set_wr(0, 10, 64'h1010); set_wr(1, 11, 64'h1111);
    exp_conf(1'b0, "conf_dist"); exp_rd(2, 10, 64'h1010, 1'b1, "byp10");
    exp_rd(3, 11, 64'h1111, 1'b1, "byp11");
    step();

    // Allocate and write to the same index: data lands, ready ends at 0.
    clear(); set_alloc(0, 12); set_wr(0, 12, 64'h55);
    exp_rd(0, 12, 64'h55, 1'b1, "aw12_byp");
    step();
    clear(); exp_rd(0, 12, 64'h55, 1'b0, "aw12_arr");
    step();

    // Write and read of idx 3 in the same cycle.
    clear(); set_wr(1, 3, 64'h77); exp_rd(1, 3, 64'h77, 1'b1, "wr3_byp");
    step();
    clear(); exp_rd(1, 3, 64'h77, 1'b1, "wr3_arr");
    step();

    // Out-of-range index is dropped and reads as 0 / not ready.
    clear(); set_wr(0, 50, 64'hFF); set_wr(1, 50, 64'hEE); set_alloc(0, 50);
    exp_conf(1'b0, "conf_oor"); exp_rd(0, 50, 64'h0, 1'b0, "oor_byp");
    step();
    clear(); exp_rd(0, 50, 64'h0, 1'b0, "oor_arr");
    exp_rd(1, 63, 64'h0, 1'b0, "oor63");
    step();

    // Two allocates at once.
    clear(); set_alloc(0, 20); set_alloc(1, 21);
    step();
    clear(); exp_rd(0, 20, 64'h0, 1'b0, "alloc20"); exp_rd(1, 21, 64'h0, 1'b0, "alloc21");
    exp_rd(2, 22, 64'h0, 1'b1, "idle22");
    step();

    // Reset mid-stream overrides same-cycle write and allocate.
    clear(); rst = 1'b1; set_wr(0, 30, 64'h99); set_wr(1, 30, 64'h98); set_alloc(0, 31);
    exp_conf(1'b1, "conf_in_rst"); exp_rst_reg("rst_mid_out");
    step();
    rst = 1'b0;
    clear();
    exp_rd(0, 5, 64'h0, 1'b1, "rst5"); exp_rd(1, 30, 64'h0, 1'b1, "rst30");
    exp_rd(2, 31, 64'h0, 1'b1, "rst31"); exp_rd(3, 12, 64'h0, 1'b1, "rst12");
    step();
    clear(); exp_rd(0, 9, 64'h0, 1'b1, "rst9"); exp_rd(1, 7, 64'h0, 1'b1, "rst7");
    exp_rd(2, 20, 64'h0, 1'b1, "rst20"); exp_rd(3, 3, 64'h0, 1'b1, "rst3");
    step();
    clear();
    step();
    step();

    n_cmp++;
    if (q0.size() + q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/preg_file_mp.md
# preg_file_mp

Multi-ported, parametrised physical register file for the out-of-order core. It replaces the single-write, dual-read PRF and adds three things: per-register ready (valid) bits, an optional registered read stage, and collision detection. It sits between the issue stage (read ports, ready lookup) and the complete/CDB stage (write ports). Dispatch drives the allocate ports to clear the ready bit of each newly renamed destination.

## Interface
- XLEN, 64, data width per register
- PRF_NUM, 64, number of physical registers; IDX_W = $clog2(PRF_NUM)
- NRD, 4, number of read ports
- NWR, 2, number of write (CDB) ports
- NALLOC, 2, number of allocate ports
- RD_REG, 0, 0 = combinational read, 1 = read data/ready registered (1-cycle latency)
- ZERO_IDX, PRF_NUM-1, hard-wired zero register index

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- rd_idx_i  in  NRD*IDX_W  read indices, port k at bits [k*IDX_W +: IDX_W]
- rd_data_o  out  NRD*XLEN  read data
- rd_rdy_o  out  NRD  ready bit of the indexed register
- wr_en_i  in  NWR  write enables
- wr_idx_i  in  NWR*IDX_W  write indices
- wr_data_i  in  NWR*XLEN  write data
- alloc_en_i  in  NALLOC  allocate enables; each clears a ready bit
- alloc_idx_i  in  NALLOC*IDX_W  allocated register indices
- wr_conflict_o  out  1  error flag: two enabled write ports target the same non-zero index this cycle

## Operation
- Storage: PRF_NUM x XLEN data array plus a PRF_NUM-bit ready vector.
- Write: each enabled port writes data[idx] and sets rdy[idx] at the clock edge.
- Write collision: the highest-numbered port wins. wr_conflict_o is combinational and asserts in the same cycle.
- Allocate: each enabled port clears rdy[idx] at the clock edge. Data is untouched.
- Allocate and write to the same index in the same cycle: data is written, and rdy ends at 0 (allocate wins).
- Zero register: writes and allocates to ZERO_IDX are ignored. Reads return 0 with rdy = 1. Excluded from conflict detection.
- Read, RD_REG=0 (combinational), in priority order:
  - ZERO_IDX -> 0, rdy 1
  - else a same-cycle enabled write to the same index -> that write's data (highest port wins), rdy 1; this bypass ignores a same-cycle allocate to that index
  - else array contents and rdy[idx]
- Read, RD_REG=1: the RD_REG=0 result is captured into an output register each cycle. Bypass therefore covers writes in the same cycle as the index.
- Out-of-range indices (>= PRF_NUM when PRF_NUM is not a power of 2): read returns 0 with rdy 0; write and allocate are ignored.

## Timing
- Reset (rst high at an edge):
  - all data = 0
  - all rdy = 1
  - registered rd_data_o = 0, rd_rdy_o = 1 when RD_REG=1
- wr_conflict_o is combinational and unaffected by reset state.
- Reset overrides any same-cycle write or allocate.
- Write latency: data and rdy are visible through the array one cycle after the write edge; with bypass they are visible in the write cycle itself.
- Allocate latency: rdy reads 0 starting the cycle after the alloc edge.
- Read latency: 0 cycles (RD_REG=0) or 1 cycle (RD_REG=1).
- No stall or backpressure: every port is accepted every cycle.

## Test plan
- Reset, then read all indices -> data 0, rdy 1. Write port 0 idx 5 = 0xDEAD_BEEF -> same-cycle read of idx 5 returns 0xDEAD_BEEF (bypass); next cycle it returns the same value from the array.
- Alloc idx 9 at cycle t -> rd_rdy_o = 0 for idx 9 at t+1. Write idx 9 = 0x1234 at t+3 -> rdy 1 and data 0x1234 visible at t+3 via bypass.
- Write ports 0 and 1 both to idx 7 (0xAAAA, 0xBBBB) -> wr_conflict_o = 1 that cycle; idx 7 reads 0xBBBB afterwards. Repeat targeting ZERO_IDX -> no conflict flag, reads stay 0.
- Alloc and write idx 12 = 0x55 in the same cycle -> next cycle data 0x55, rdy 0.
- RD_REG=1: present idx 3 while writing idx 3 = 0x77 -> rd_data_o = 0x77 and rdy 1 one cycle later.
- Random multi-port traffic against a scoreboard model for 10k cycles; assert rst mid-stream -> all outputs match the reset values on the following cycle.
